// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched instructions with flush.
// The head is taken straight from the storage registers.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t in_entry,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0, instr: NOP_INSTR, fault: 1'b0};

    fetch_entry_t entries [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         pop_ok;
    logic         push_ok;

    // Guards keep the pointers and count consistent even if a caller misbehaves.
    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'd2) || pop_ok);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entries[0] <= EMPTY_ENTRY;
            entries[1] <= EMPTY_ENTRY;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                entries[wr_ptr] <= in_entry;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = entries[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC, fault check, and a 2-entry buffer toward decode.
// A faulting fetch enqueues a NOP marked as a fault and halts until redirected.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    output logic        out_fault
);

    localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic         fault;
    logic         push;
    logic         pop;
    logic [1:0]   count;
    fetch_entry_t in_entry;
    fetch_entry_t head;

    assign iaddr = pc_q;
    assign fault = (pc_q[1:0] != 2'b00) || (pc_q[31:2] >= IMEM_LIMIT);
    assign pop   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = RUN;
        end else if (push && fault) begin
            state_d = HALT;
        end
    end

    // Push whenever running and there is room, counting a slot freed by a same-cycle pop.
    always_comb begin
        push           = (state_q == RUN) && !redirect_valid && ((count < 2'd2) || pop);
        in_entry.pc    = pc_q;
        in_entry.instr = fault ? NOP_INSTR : idata;
        in_entry.fault = fault;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc;
        end else if (push && !fault) begin
            pc_q <= pc_q + 32'd4;
        end
    end

    fetch_buf u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .in_entry (in_entry),
        .head     (head),
        .count    (count)
    );

    assign out_valid = (count != 2'd0);
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign out_pc4   = head.pc + 32'd4;
    assign out_fault = head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction-memory model.
// Memory word at byte address a holds 0xC0DE0000 + a; out-of-range reads return 0xDEADBEEF.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic        out_fault;

    int errors;
    int checks;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .iaddr          (iaddr),
        .idata          (idata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc4        (out_pc4),
        .out_fault      (out_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (iaddr[31:2] < 30'd32) begin
            idata = 32'hC0DE_0000 + {iaddr[31:2], 2'b00};
        end else begin
            idata = 32'hDEAD_BEEF;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic ready, input logic rv, input logic [31:0] rpc);
        rst_n          = rst;
        out_ready      = ready;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkHead(input string tag, input logic [31:0] pc, input logic [31:0] instr, input logic flt);
        checkOutput({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        checkOutput({tag, ".pc"}, out_pc, pc);
        checkOutput({tag, ".instr"}, out_instr, instr);
        checkOutput({tag, ".pc4"}, out_pc4, pc + 32'd4);
        checkOutput({tag, ".fault"}, {31'd0, out_fault}, {31'd0, flt});
    endtask

    initial begin
        errors = 0;
        checks = 0;

        // Reset state
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        step();
        checkOutput("rst.valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst.instr", out_instr, 32'h0000_0013);
        checkOutput("rst.pc", out_pc, 32'h0);
        checkOutput("rst.pc4", out_pc4, 32'h4);
        checkOutput("rst.fault", {31'd0, out_fault}, 32'd0);
        checkOutput("rst.iaddr", iaddr, 32'h0);

        // Streaming with ready held high
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            checkHead("stream", 32'(4 * k), 32'hC0DE_0000 + 32'(4 * k), 1'b0);
        end

        // Backpressure: buffer fills, pc holds at 8
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
        end
        checkOutput("bp.iaddr", iaddr, 32'h8);
        checkHead("bp.hold", 32'h0, 32'hC0DE_0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        checkHead("bp.rel1", 32'h4, 32'hC0DE_0004, 1'b0);
        checkOutput("bp.iaddr2", iaddr, 32'hC);
        step();
        checkHead("bp.rel2", 32'h8, 32'hC0DE_0008, 1'b0);

        // Redirect while full and popping
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h10);
        step();
        checkOutput("redir.valid", {31'd0, out_valid}, 32'd0);
        checkOutput("redir.iaddr", iaddr, 32'h10);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        checkHead("redir.head", 32'h10, 32'hC0DE_0010, 1'b0);

        // Misaligned redirect: one fault entry, then halt
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h12);
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        checkHead("mis.head", 32'h12, 32'h0000_0013, 1'b1);
        step();
        checkOutput("mis.valid1", {31'd0, out_valid}, 32'd0);
        step();
        checkOutput("mis.valid2", {31'd0, out_valid}, 32'd0);
        checkOutput("mis.iaddr", iaddr, 32'h12);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0);
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        checkHead("mis.resume", 32'h0, 32'hC0DE_0000, 1'b0);

        // Sequential fetch off the end of memory
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h78);
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        checkHead("end.78", 32'h78, 32'hC0DE_0078, 1'b0);
        step();
        checkHead("end.7c", 32'h7C, 32'hC0DE_007C, 1'b0);
        step();
        checkHead("end.80", 32'h80, 32'h0000_0013, 1'b1);
        checkOutput("end.iaddr", iaddr, 32'h80);
        step();
        checkOutput("end.halt", {31'd0, out_valid}, 32'd0);
        checkOutput("end.iaddr2", iaddr, 32'h80);

        // Top-of-address-space redirect: out_pc4 wraps to zero
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        checkOutput("wrap.valid", {31'd0, out_valid}, 32'd1);
        checkOutput("wrap.pc4", out_pc4, 32'h0);
        checkOutput("wrap.fault", {31'd0, out_fault}, 32'd1);

        // Reset while full mid-stream
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        step();
        checkOutput("mid.iaddr", iaddr, 32'h8);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        checkOutput("mid.valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid.iaddr2", iaddr, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        checkHead("mid.resume", 32'h0, 32'hC0DE_0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32I core, directly upstream of the instruction memory. Holds the program counter, drives the word address into the combinational instruction memory, captures the returned word together with its PC into a 2-entry fetch buffer, and presents it to decode over a valid/ready handshake. Supports redirects (branch/jump/trap) that flush the buffer, and flags misaligned or out-of-range fetch addresses.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- IMEM_WORDS, 32, instruction memory depth in 32-bit words; legal PC range is [0, 4*IMEM_WORDS)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- iaddr  out  32  byte address to instruction memory (maps to Instr_IO iaddr)
- idata  in  32  instruction word from memory, valid in the same cycle as iaddr (maps to Instr_IO idata)
- redirect_valid  in  1  load redirect_pc as next fetch PC, flush buffer
- redirect_pc  in  32  redirect target
- out_valid  out  1  buffer head holds an entry
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  32  instruction at head
- out_pc  out  32  PC of head
- out_pc4  out  32  out_pc + 4 (mod 2^32)
- out_fault  out  1  head entry is a fetch fault

## Operation

- Registers: pc (32), state {RUN, HALT}, buffer of 2 entries {pc, instr, fault}, count 0..2.
- Reset (rst_n low at edge): pc=RESET_PC, state=RUN, count=0; outputs: out_valid=0, out_instr=32'h0000_0013, out_pc=0, out_pc4=4, out_fault=0. iaddr=RESET_PC.
- iaddr = pc at all times (also in HALT).
- pop = out_valid & out_ready.
- push = state==RUN & !redirect_valid & (count<2 | pop).
- Fault check on pc: fault = (pc[1:0]!=0) | (pc[31:2] >= IMEM_WORDS).
- On push without fault: enqueue {pc, idata, 0}; pc <= pc+4 (wraps mod 2^32).
- On push with fault: enqueue {pc, 32'h0000_0013, 1}; pc holds; state <= HALT.
- HALT: no pushes; buffered entries still drain normally.
- redirect_valid (any state): count <= 0, pc <= redirect_pc, state <= RUN; no push that cycle. A pop in the same cycle completes at the handshake but its entry is discarded with the flush. redirect_pc is not checked until it is fetched.
- Priority: rst_n > redirect_valid > pop/push.
- Buffer order is strict FIFO; head outputs come from registered state only.

## Timing

- Memory path: pc -> iaddr -> idata -> buffer input is combinational within one cycle.
- Latency: entry pushed at edge N is visible at head (out_valid=1) after edge N. First out_valid=1 after the first edge with rst_n high.
- Throughput: 1 entry/cycle with out_ready held high; count stays at 1.
- Full (count==2), no pop: no push, pc and iaddr hold.
- Full with pop: push and pop in same cycle, count stays 2.
- Empty with push: out_valid rises next cycle; no bypass from idata to out_*.
- Redirect at edge N: out_valid=0 after N; first entry from redirect_pc pushed at N+1, visible after N+1 (2-cycle redirect-to-valid).
- Reset mid-stream: all entries dropped, pc=RESET_PC after that edge.

## Structure

- fetch_pkg: NOP_INSTR = 32'h0000_0013; fetch_entry_t struct {pc, instr, fault}; fetch_state_t enum {RUN, HALT}.
- Sub-module fetch_buf: 2-entry FIFO of fetch_entry_t with push/pop/flush, count, head outputs; same clk/rst_n.
- fetch_unit holds pc, state, fault check, push logic, and out_pc4 adder.

## Test plan

- Reset then out_ready=1, imem words 0..3 = A,B,C,D: out stream (0,A),(4,B),(8,C),(12,D) on consecutive cycles, out_pc4 = 4,8,12,16.
- out_ready=0 for 5 cycles after reset: count reaches 2, iaddr holds 8, heads (0,A) then (4,B) after release, no loss or duplication.
- redirect_valid with redirect_pc=0x10 while count=2 and out_ready=1: out_valid=0 next cycle, then head (0x10, word 4) after one more cycle.
- redirect_pc=0x12: one entry {0x12, NOP, fault=1}, then no further out_valid; iaddr stuck at 0x12 until redirect to 0x0 resumes with (0,A).
- Sequential fetch to 4*IMEM_WORDS=0x80: entry at 0x7C normal, entry at 0x80 has out_fault=1, out_instr=0x13, state HALT.
- rst_n low for one edge while count=2 and mid-fetch: after edge out_valid=0, iaddr=RESET_PC; following edge resumes at (RESET_PC, word 0).
